imem_port_arbiter: RTL and testbench

Arbiter sharing the single instruction-memory port between the CPU fetch stage and a loader/debug port. Pipelined; one request accepted per cycle. Memory is synchronous, read data returned the cycle after the address. Sits between the fetch stage, the loader, and the instruction memory; it forwards byte addresses unchanged, and word indexing stays inside the memory.

---
 rtl/imem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one instruction-memory port between fetch and loader
//
// Purpose:
//   Pipelined arbiter in front of a synchronous instruction memory. One request
//   is granted per cycle. Read data returns the cycle after the grant and is
//   steered to the port that issued it, as recorded in a 2-bit owner register.
//   The loader has priority over fetch. When IMEM_ARB_STARVE_GUARD_EN is defined,
//   a starve counter lets fetch win once the loader has been granted
//   STARVE_LIMIT times in a row while fetch was waiting.
//
// Configuration macro: IMEM_ARB_STARVE_GUARD_EN (fetch anti-starvation guard)
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   f_req/f_addr/f_gnt                fetch request, byte address, grant
//   f_flush                           cancel in-flight / same-cycle fetch response
//   f_rvalid/f_rdata                  fetch read response
//   d_req/d_we/d_addr/d_wdata/d_gnt   loader request and grant
//   d_rvalid/d_rdata                  loader read response
//   mem_en/mem_we/mem_addr/mem_wdata  memory request side
//   mem_rdata                         memory read data, one cycle after mem_en

module imem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    input  logic              f_flush,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic              r_f_cancel;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_f_gnt;
    logic              w_d_gnt;
    logic              w_fetch_first;

    // Only a limit of 1..15 fits the 4-bit starve counter; an out-of-range
    // value leaves this marker block visible in the elaborated hierarchy.
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_starve_limit_out_of_range
    end

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;

    assign w_fetch_first = (r_starve == LP_LIMIT);

    // Counts loader grants taken while fetch was waiting. It cannot pass the
    // limit: at the limit either fetch wins (clear) or f_req is low (clear).
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_f_gnt || !f_req) begin
            w_starve_nxt = 4'd0;
        end else if (w_d_gnt) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else begin
            r_starve <= w_starve_nxt;
        end
    end
`else
    assign w_fetch_first = 1'b0;
`endif

    // Grants are gated by reset so outputs return to idle as soon as reset
    // rises, without waiting for a clock edge.
    assign w_d_gnt = !reset && d_req && !(f_req && w_fetch_first);
    assign w_f_gnt = !reset && f_req && !w_d_gnt;

    always_comb begin
        f_gnt       = w_f_gnt;
        d_gnt       = w_d_gnt;
        mem_en      = w_f_gnt || w_d_gnt;
        mem_we      = w_d_gnt && d_we;
        mem_addr    = r_mem_addr;
        mem_wdata   = r_mem_wdata;
        w_owner_nxt = OWN_IDLE;
        f_rvalid    = 1'b0;
        f_rdata     = '0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;

        if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we) begin
                w_owner_nxt = OWN_LOAD;
            end
        end else if (w_f_gnt) begin
            mem_addr    = f_addr;
            w_owner_nxt = OWN_FETCH;
        end

        // A fetch response dies if it was flushed in its grant cycle
        // (r_f_cancel) or is flushed in the cycle it returns.
        if (r_owner == OWN_FETCH && !r_f_cancel && !f_flush) begin
            f_rvalid = 1'b1;
            f_rdata  = mem_rdata;
        end
        if (r_owner == OWN_LOAD) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_IDLE;
            r_f_cancel  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_f_cancel  <= w_f_gnt && f_flush;
            r_mem_addr  <= mem_addr;
            r_mem_wdata <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - self-checking bench for imem_port_arbiter

module tb_imem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          f_req, f_flush, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [DW-1:0] f_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_init;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_flush(f_flush),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Synchronous memory environment: 64 words, indexed by byte address [7:2].
    logic [31:0] mem [0:63];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        f_req = fr; f_addr = fa; f_flush = ff;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    task automatic idle;
        drive(1'b0, f_addr, 1'b0, 1'b0, 1'b0, d_addr, d_wdata);
    endtask

    task automatic wr_then_fetch(input logic [31:0] a, input logic [31:0] d, input string tag);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, a, d);
        #4;
        chk({tag, "_wr_dgnt"}, d_gnt, 1);
        chk({tag, "_wr_we"}, mem_we, 1);
        tick;
        drive(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        chk({tag, "_fgnt"}, f_gnt, 1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_no_drvalid"}, d_rvalid, 0);
        tick;
        idle;
        #4;
        chk({tag, "_frvalid"}, f_rvalid, 1);
        chk({tag, "_frdata"}, f_rdata, d);
        chk({tag, "_drvalid"}, d_rvalid, 0);
        tick;
    endtask

    typedef struct {
        logic fr, dr, dwe;
        logic efg, edg, ewe;
    } vec_t;

    vec_t tbl [8];

    // reference model state for the randomized phase
    logic [31:0] ref_mem [0:63];
    int          pend_kind;     // 0 none, 1 fetch, 2 loader
    logic [31:0] pend_data;
    logic        pend_cancel;
    int          cnt;
    logic [31:0] last_addr, last_wdata;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 1, 0, 1, 1};
        tbl[3] = '{1, 1, 0, 0, 1, 0};
        tbl[4] = '{1, 1, 1, 0, 1, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 0};

        reset = 1'b1; mem_init = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick;
        mem_init = 1'b0;
        #2;
        chk("rst_fgnt", f_gnt, 0);       chk("rst_dgnt", d_gnt, 0);
        chk("rst_frvalid", f_rvalid, 0); chk("rst_drvalid", d_rvalid, 0);
        chk("rst_frdata", f_rdata, 0);   chk("rst_drdata", d_rdata, 0);
        chk("rst_mem_en", mem_en, 0);    chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        tick;
        reset = 1'b0;
        tick;

        wr_then_fetch(32'h4, 32'h2008_0005, "fetch4");
        wr_then_fetch(32'h8, 32'hDEAD_BEEF, "wrfetch8");

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].fr, 32'h100, 0, tbl[i].dr, tbl[i].dwe, 32'hF0, 32'h1234_0000 + i);
            #4;
            chk($sformatf("tbl%0d_fgnt", i), f_gnt, tbl[i].efg);
            chk($sformatf("tbl%0d_dgnt", i), d_gnt, tbl[i].edg);
            chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].efg | tbl[i].edg);
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].ewe);
            tick;
            idle;
            tick;
        end

        // both ports requesting continuously, loader reads
        for (int i = 0; i < 15; i++) begin
            logic [1:0] exp_g;
`ifdef IMEM_ARB_STARVE_GUARD_EN
            exp_g = ((i % (LIMIT + 1)) == LIMIT) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            drive(1, 32'h24, 0, 1, 0, 32'h20, 32'h0);
            #4;
            chk($sformatf("starve%0d_gnt", i), {f_gnt, d_gnt}, exp_g);
            tick;
        end
        idle;
        tick;

        // flush corner cases
        drive(1, 32'h30, 0, 0, 0, 32'h0, 32'h0); #4;
        chk("fl_gnt0", f_gnt, 1); tick;
        drive(0, 32'h0, 1, 0, 0, 32'h0, 32'h0); #4;
        chk("fl_suppress", f_rvalid, 0); tick;
        drive(1, 32'h34, 0, 0, 0, 32'h0, 32'h0); #4;
        chk("fl_gnt_after", f_gnt, 1); chk("fl_none", f_rvalid, 0); tick;
        drive(1, 32'h38, 0, 0, 0, 32'h0, 32'h0); #4;
        chk("fl_ret_valid", f_rvalid, 1); chk("fl_ret_data", f_rdata, init_word(13)); tick;
        drive(1, 32'h3C, 1, 0, 0, 32'h0, 32'h0); #4;
        chk("fl_gnt_during", f_gnt, 1); chk("fl_suppress2", f_rvalid, 0); tick;
        idle; #4;
        chk("fl_cancel_same", f_rvalid, 0); tick;

        // reset pulsed in the cycle after a loader read grant
        drive(1, 32'h44, 0, 1, 0, 32'h40, 32'h5555_AAAA); #4;
        chk("rm_dgnt", d_gnt, 1); tick;
        chk("rm_pre_drvalid", d_rvalid, 1);
        #1 reset = 1'b1;
        #1;
        chk("rm_drvalid", d_rvalid, 0); chk("rm_drdata", d_rdata, 0);
        chk("rm_fgnt", f_gnt, 0);       chk("rm_dgnt0", d_gnt, 0);
        chk("rm_mem_en", mem_en, 0);    chk("rm_mem_addr", mem_addr, 0);
        chk("rm_mem_wdata", mem_wdata, 0);
        tick;
        reset = 1'b0;
        idle; #4;
        chk("rm_after1", {f_rvalid, d_rvalid}, 0); tick;
        #4;
        chk("rm_after2", {f_rvalid, d_rvalid}, 0); tick;

        // back-to-back fetches
        drive(1, 32'h10, 0, 0, 0, 32'h0, 32'h0); #4;
        chk("b2b_gnt0", f_gnt, 1); tick;
        drive(1, 32'h14, 0, 0, 0, 32'h0, 32'h0); #4;
        chk("b2b_gnt1", f_gnt, 1); chk("b2b_v0", f_rvalid, 1);
        chk("b2b_d0", f_rdata, init_word(4)); tick;
        idle; #4;
        chk("b2b_v1", f_rvalid, 1); chk("b2b_d1", f_rdata, init_word(5)); tick;

        // randomized phase against the reference model
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        pend_kind = 0; pend_data = '0; pend_cancel = 1'b0; cnt = 0;
        last_addr = 32'h14; last_wdata = 32'h0;
        for (int c = 0; c < 400; c++) begin
            logic fr, dr, dwe, ff, fw, dw;
            logic [31:0] fa, da, wd, e_addr, e_wdata;
            fr  = ($urandom_range(0, 99) < 75);
            dr  = ($urandom_range(0, 99) < 55);
            dwe = $urandom_range(0, 1);
            ff  = ($urandom_range(0, 99) < 15);
            fa  = $urandom() & 32'hFFFF_FFFC;
            da  = $urandom() & 32'hFFFF_FFFC;
            wd  = $urandom();
            drive(fr, fa, ff, dr, dwe, da, wd);
`ifdef IMEM_ARB_STARVE_GUARD_EN
            dw = dr && !(fr && cnt == LIMIT);
`else
            dw = dr;
`endif
            fw = fr && !dw;
            e_addr  = dw ? da : (fw ? fa : last_addr);
            e_wdata = dw ? wd : last_wdata;
            #4;
            chk($sformatf("r%0d_fgnt", c), f_gnt, fw);
            chk($sformatf("r%0d_dgnt", c), d_gnt, dw);
            chk($sformatf("r%0d_en", c), mem_en, fw | dw);
            chk($sformatf("r%0d_we", c), mem_we, dw & dwe);
            chk($sformatf("r%0d_addr", c), mem_addr, e_addr);
            chk($sformatf("r%0d_wdata", c), mem_wdata, e_wdata);
            chk($sformatf("r%0d_frvalid", c), f_rvalid, pend_kind == 1 && !pend_cancel && !ff);
            if (pend_kind == 1 && !pend_cancel && !ff)
                chk($sformatf("r%0d_frdata", c), f_rdata, pend_data);
            chk($sformatf("r%0d_drvalid", c), d_rvalid, pend_kind == 2);
            chk($sformatf("r%0d_drdata", c), d_rdata, (pend_kind == 2) ? pend_data : 32'h0);
            pend_kind = 0;
            if (fw) begin
                pend_kind = 1; pend_data = ref_mem[fa[7:2]]; pend_cancel = ff;
            end else if (dw && !dwe) begin
                pend_kind = 2; pend_data = ref_mem[da[7:2]];
            end else if (dw) begin
                ref_mem[da[7:2]] = wd;
            end
            if (fw || !fr) cnt = 0;
            else if (dw) cnt = cnt + 1;
            last_addr = e_addr; last_wdata = e_wdata;
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
